uart_core_param: RTL and testbench

- Parametrised UART transceiver: run-time programmable baud divisor, TX FIFO with valid/ready write port, RX with parity and framing error reporting, internal loopback mode.
- Next-generation replacement for the fixed 8N1 TX/RX/baud-generator top level; drops into the same single-clock UART subsystem.
- Serial pins are `tx` (output) and `rx` (input).

---
 rtl/uart_core_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// Parametrised UART transceiver: programmable baud tick, TX FIFO, TX/RX framing
// with optional parity, frame error detection and internal loopback.
module uart_core_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam logic        PAR_ODD = 1'(PARITY_ODD);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Baud tick; the divisor is re-latched only at wrap so changes never shorten a tick
  logic [DIV_W-1:0] r_div_cnt, r_div_lat, w_div_eff;
  logic             w_tick;

  assign w_div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign w_tick    = (r_div_cnt == r_div_lat - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_div_lat <= w_div_eff;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_div_lat <= w_div_eff;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // TX FIFO
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 w_full, w_empty, w_wr, w_pop;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign tx_ready = !w_full || w_pop;
  assign w_wr     = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // TX FSM
  state_t               r_tx_state, w_tx_nxt;
  logic [OS_W-1:0]      r_tx_tcnt;
  logic [BC_W-1:0]      r_tx_bcnt;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par, r_tx_line, r_tx_pin, r_tx_busy, r_tx_done_q, r_tx_done;
  logic                 w_tx_bit_end, w_tx_bit, w_tx_done;

  always_comb begin
    w_tx_nxt     = r_tx_state;
    w_pop        = 1'b0;
    w_tx_done    = 1'b0;
    w_tx_bit     = 1'b1;
    w_tx_bit_end = w_tick && (r_tx_tcnt == OS_W'(OVERSAMPLE - 1));
    case (r_tx_state)
      S_IDLE: begin
        if (w_tick && !w_empty) begin
          w_tx_nxt = S_START;
          w_pop    = 1'b1;
        end
      end
      S_START: begin
        w_tx_bit = 1'b0;
        if (w_tx_bit_end) w_tx_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_bit = r_tx_shift[0];
        if (w_tx_bit_end && r_tx_bcnt == BC_W'(DATA_BITS - 1))
          w_tx_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tx_bit = r_tx_par;
        if (w_tx_bit_end) w_tx_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tx_bit_end && r_tx_bcnt == BC_W'(STOP_BITS - 1)) begin
          w_tx_done = 1'b1;
          if (!w_empty) begin
            w_tx_nxt = S_START;
            w_pop    = 1'b1;
          end else begin
            w_tx_nxt = S_IDLE;
          end
        end
      end
      default: w_tx_nxt = S_IDLE;
    endcase
  end

  // done is delayed one extra stage so it lines up with the registered tx line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state  <= S_IDLE;
      r_tx_tcnt   <= '0;
      r_tx_bcnt   <= '0;
      r_tx_shift  <= '0;
      r_tx_par    <= 1'b0;
      r_tx_line   <= 1'b1;
      r_tx_pin    <= 1'b1;
      r_tx_busy   <= 1'b0;
      r_tx_done_q <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_nxt;
      if (w_pop) begin
        r_tx_shift <= r_mem[r_rptr];
        r_tx_par   <= (^r_mem[r_rptr]) ^ PAR_ODD;
      end else if (r_tx_state == S_DATA && w_tx_bit_end) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
      if (r_tx_state == S_IDLE)  r_tx_tcnt <= '0;
      else if (w_tick)           r_tx_tcnt <= w_tx_bit_end ? '0 : r_tx_tcnt + OS_W'(1);
      if (w_tx_nxt != r_tx_state) r_tx_bcnt <= '0;
      else if (w_tx_bit_end)      r_tx_bcnt <= r_tx_bcnt + BC_W'(1);
      r_tx_line   <= w_tx_bit;
      r_tx_pin    <= loopback | w_tx_bit;
      r_tx_busy   <= (r_tx_state != S_IDLE);
      r_tx_done_q <= w_tx_done;
      r_tx_done   <= r_tx_done_q;
    end
  end

  assign tx      = r_tx_pin;
  assign tx_busy = r_tx_busy;
  assign tx_done = r_tx_done;

  // RX synchroniser and FSM
  state_t               r_rx_state, w_rx_nxt;
  logic                 r_rx_s1, r_rx_s2, w_rx_in;
  logic [OS_W-1:0]      r_rx_tcnt, w_rx_mid;
  logic [BC_W-1:0]      r_rx_bcnt;
  logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
  logic                 r_rx_pbit, r_rx_valid, r_rx_perr, r_rx_ferr;
  logic                 w_rx_smp, w_rx_fin;

  assign w_rx_in = loopback ? r_tx_line : rx;

  always_comb begin
    w_rx_nxt = r_rx_state;
    w_rx_fin = 1'b0;
    w_rx_mid = (r_rx_state == S_START) ? OS_W'(OVERSAMPLE / 2 - 1) : OS_W'(OVERSAMPLE - 1);
    w_rx_smp = (r_rx_state != S_IDLE) && w_tick && (r_rx_tcnt == w_rx_mid);
    case (r_rx_state)
      S_IDLE:   if (!r_rx_s2) w_rx_nxt = S_START;
      S_START:  if (w_rx_smp) w_rx_nxt = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_rx_smp && r_rx_bcnt == BC_W'(DATA_BITS - 1))
          w_rx_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_rx_smp) w_rx_nxt = S_STOP;
      S_STOP: begin
        if (w_rx_smp) begin
          w_rx_nxt = S_IDLE;
          w_rx_fin = 1'b1;
        end
      end
      default:  w_rx_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_shift <= '0;
      r_rx_pbit  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1    <= w_rx_in;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_nxt;
      if (r_rx_state == S_IDLE || w_rx_smp) r_rx_tcnt <= '0;
      else if (w_tick)                      r_rx_tcnt <= r_rx_tcnt + OS_W'(1);
      if (r_rx_state != S_DATA) r_rx_bcnt <= '0;
      else if (w_rx_smp)        r_rx_bcnt <= r_rx_bcnt + BC_W'(1);
      if (r_rx_state == S_DATA && w_rx_smp)
        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
      if (r_rx_state == S_PARITY && w_rx_smp) r_rx_pbit <= r_rx_s2;
      r_rx_valid <= w_rx_fin;
      if (w_rx_fin) begin
        r_rx_data <= r_rx_shift;
        r_rx_perr <= (PARITY_EN != 0) && (r_rx_pbit != ((^r_rx_shift) ^ PAR_ODD));
        r_rx_ferr <= !r_rx_s2;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three instances (8N1, 8E1, 8O1) checked against a
// frame-level model of the serial waveform and of received words/flags.
module tb_uart_core_param;
  localparam int unsigned NI = 3;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic [15:0]   baud_div = 16'd4;
  logic [NI-1:0] loopback = '0;
  logic [NI-1:0] tx_valid = '0;
  logic [NI-1:0] rx       = '1;
  logic [7:0]    tx_data  = 8'h00;
  wire  [NI-1:0] tx_ready, tx, tx_busy, tx_done, rx_valid, rx_perr, rx_ferr;
  wire  [7:0]    rx_data [NI];

  int total = 0;
  int bad   = 0;
  logic [7:0] cap_words [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_core_param #(
      .DATA_BITS(8), .PARITY_EN((g > 0) ? 1 : 0), .PARITY_ODD((g == 2) ? 1 : 0),
      .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4), .DIV_W(16)
    ) u_dut (
      .clk(clk), .reset(reset), .baud_div(baud_div), .loopback(loopback[g]),
      .tx_data(tx_data), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .tx(tx[g]), .tx_busy(tx_busy[g]), .tx_done(tx_done[g]), .rx(rx[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .rx_parity_err(rx_perr[g]), .rx_frame_err(rx_ferr[g])
    );
  end

  // Frame model: start, 8 data LSB first, optional parity (even g=1, odd g=2), stop
  function automatic int flen(input int g);
    return (g > 0) ? 11 : 10;
  endfunction

  function automatic logic fbit(input int g, input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (g > 0 && idx == 9) return (^d) ^ (g == 2);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input int g, input logic [7:0] d);
    int w;
    w = 0;
    tx_data = d;
    tx_valid[g] = 1'b1;
    while (tx_ready[g] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("write_ready", 32'(tx_ready[g]), 32'd1);
    @(negedge clk);
    tx_valid[g] = 1'b0;
  endtask

  // Waits for the first start bit, then compares every cycle of n frames plus idle
  task automatic capture(input int g, input int n, input string tag, output int ready_low);
    int w, len, werr, cerr;
    w = 0; werr = 0; cerr = 0; ready_low = 0;
    len = flen(g) * 64;
    while (tx[g] !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start_seen"}, 32'(w < 400), 32'd1);
    for (int c = 0; c < n * len + 64; c++) begin
      logic e;
      e = (c < n * len) ? fbit(g, cap_words[c / len], (c % len) / 64) : 1'b1;
      if (tx[g] !== e) werr++;
      if (tx_done[g] !== ((c > 0 && c % len == 0 && c <= n * len) ? 1'b1 : 1'b0)) cerr++;
      if (tx_busy[g] !== ((c < n * len) ? 1'b1 : 1'b0)) cerr++;
      if (tx_ready[g] !== 1'b1) ready_low++;
      @(negedge clk);
    end
    chk({tag, "_wave_err"}, 32'(werr), 32'd0);
    chk({tag, "_done_busy_err"}, 32'(cerr), 32'd0);
  endtask

  task automatic lb_one(input int g, input logic [7:0] d);
    int nv, pinlow;
    logic [7:0] gd;
    logic gp, gf;
    nv = 0; pinlow = 0; gd = 8'h00; gp = 1'b0; gf = 1'b0;
    loopback[g] = 1'b1;
    ticks(2);
    write_word(g, d);
    for (int c = 0; c < 1000; c++) begin
      if (tx[g] !== 1'b1) pinlow++;
      if (rx_valid[g] === 1'b1) begin
        nv++; gd = rx_data[g]; gp = rx_perr[g]; gf = rx_ferr[g];
      end
      @(negedge clk);
    end
    loopback[g] = 1'b0;
    chk("lb_valid_count", 32'(nv), 32'd1);
    chk("lb_data", 32'(gd), 32'(d));
    chk("lb_perr", 32'(gp), 32'd0);
    chk("lb_ferr", 32'(gf), 32'd0);
    chk("lb_pin_high", 32'(pinlow), 32'd0);
  endtask

  // Drives one external frame (64 cycles/bit); a low stop bit is released early
  task automatic rx_frame(input int g, input logic [7:0] d, input logic flip, input logic stopv);
    int len, nv;
    logic [7:0] gd;
    logic gp, gf;
    len = flen(g); nv = 0; gd = 8'h00; gp = 1'b0; gf = 1'b0;
    for (int c = 0; c < (len + 2) * 64; c++) begin
      int b;
      logic v;
      b = c / 64;
      if (b == len - 1)      v = (c % 64 < 48) ? stopv : 1'b1;
      else if (b < len)      v = fbit(g, d, b) ^ ((g > 0 && b == 9) ? flip : 1'b0);
      else                   v = 1'b1;
      rx[g] = v;
      if (rx_valid[g] === 1'b1) begin
        nv++; gd = rx_data[g]; gp = rx_perr[g]; gf = rx_ferr[g];
      end
      @(negedge clk);
    end
    chk("ext_valid_count", 32'(nv), 32'd1);
    chk("ext_data", 32'(gd), 32'(d));
    chk("ext_perr", 32'(gp), 32'((g > 0) ? flip : 1'b0));
    chk("ext_ferr", 32'(gf), 32'(!stopv));
  endtask

  initial begin
    int rl, w, nv, bad_idle, g;
    logic [7:0] d;
    @(negedge clk);
    ticks(3);
    for (int i = 0; i < NI; i++) begin
      chk("rst_tx", 32'(tx[i]), 32'd1);
      chk("rst_busy_done", 32'({tx_busy[i], tx_done[i]}), 32'd0);
      chk("rst_ready", 32'(tx_ready[i]), 32'd1);
      chk("rst_rx", 32'({rx_data[i], rx_valid[i], rx_perr[i], rx_ferr[i]}), 32'd0);
    end
    reset = 1'b0;
    ticks(4);

    // 8N1 0xA5 waveform and tx_done timing
    cap_words[0] = 8'hA5;
    fork
      capture(0, 1, "n81_a5", rl);
      write_word(0, 8'hA5);
    join
    chk("n81_ready_high", 32'(rl), 32'd0);

    // Loopback: directed 8E1 0x3C, then random words and divisors (0 means 1)
    lb_one(1, 8'h3C);
    for (int k = 0; k < 6; k++) begin
      baud_div = 16'($urandom_range(0, 4));
      ticks(10);
      lb_one(k % 3, 8'($urandom));
    end
    baud_div = 16'd4;
    ticks(10);

    // FIFO: 5 back-to-back writes, 6th held off, 5 contiguous frames
    for (int k = 0; k < 5; k++) cap_words[k] = 8'($urandom);
    fork
      capture(0, 5, "fifo5", rl);
      begin
        for (int k = 0; k < 5; k++) write_word(0, cap_words[k]);
        tx_data = 8'h77;
        tx_valid[0] = 1'b1;
        chk("fifo_full_hold", 32'(tx_ready[0]), 32'd0);
        @(negedge clk);
        chk("fifo_full_hold2", 32'(tx_ready[0]), 32'd0);
        tx_valid[0] = 1'b0;
      end
    join

    // External RX: 8O1 wrong parity, low stop bit, clean, then random mixes
    rx_frame(2, 8'h01, 1'b1, 1'b1);
    rx_frame(2, 8'h01, 1'b0, 1'b0);
    rx_frame(1, 8'hC3, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      g = $urandom_range(0, 2);
      rx_frame(g, 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Glitch of 3 ticks on idle line, then a valid frame right after
    nv = 0;
    for (int c = 0; c < 128; c++) begin
      rx[0] = (c < 12) ? 1'b0 : 1'b1;
      if (rx_valid[0] === 1'b1) nv++;
      @(negedge clk);
    end
    chk("glitch_no_valid", 32'(nv), 32'd0);
    rx_frame(0, 8'($urandom), 1'b0, 1'b1);

    // Reset in the middle of DATA with two words still queued
    for (int k = 0; k < 3; k++) write_word(0, 8'($urandom));
    w = 0;
    while (tx[0] !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_start_seen", 32'(w < 400), 32'd1);
    ticks(3 * 64);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", 32'(tx[0]), 32'd1);
    chk("rst_mid_busy", 32'(tx_busy[0]), 32'd0);
    chk("rst_mid_ready", 32'(tx_ready[0]), 32'd1);
    chk("rst_mid_done", 32'(tx_done[0]), 32'd0);
    reset = 1'b0;
    bad_idle = 0;
    for (int c = 0; c < 1500; c++) begin
      if (tx[0] !== 1'b1 || tx_done[0] !== 1'b0 || tx_busy[0] !== 1'b0 || tx_ready[0] !== 1'b1)
        bad_idle++;
      @(negedge clk);
    end
    chk("rst_mid_fifo_empty", 32'(bad_idle), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
